// File: rtl/game_turn_ctrl.sv
// Turn sequencer for a 2..4 player board game.
// Walks IDLE -> TURN -> GO -> IDLE, rotates the current player on every
// accepted move and latches the game result until the next game starts.
// Optional feature macro: TURN_TIMEOUT_EN compiles in the idle-turn skip
// (idle counter, automatic player advance and the timeout_skip pulse).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a start strobe; result/winner of last game held
// S_TURN | game running, play_en enables the current player's move
// S_GO   | game over, held for GO_HOLD cycles, play ignored
module game_turn_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int GO_HOLD     = 4,
    parameter int MCW         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   play,
    input  logic                   ill,
    input  logic                   nospc,
    input  logic                   win,
    input  logic [1:0]             win_id,
    output logic [NUM_PLAYERS-1:0] play_en,
    output logic [1:0]             cur_player,
    output logic                   game_over,
    output logic [1:0]             result,
    output logic [1:0]             winner,
    output logic [MCW-1:0]         move_cnt,
    output logic                   timeout_skip
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_GO   = 2'd2
    } state_t;

    localparam logic [1:0]             RES_NONE    = 2'b00;
    localparam logic [1:0]             RES_WIN     = 2'b01;
    localparam logic [1:0]             RES_DRAW    = 2'b10;
    localparam logic [1:0]             LAST_PLAYER = 2'(NUM_PLAYERS - 1);
    localparam logic [7:0]             GO_LAST     = 8'(GO_HOLD - 1);
    localparam logic [MCW-1:0]         MC_MAX      = {MCW{1'b1}};
    localparam logic [MCW-1:0]         MC_ONE      = MCW'(1);
    localparam logic [NUM_PLAYERS-1:0] PE_ONE      = NUM_PLAYERS'(1);

    // Parameter legality is checked once at elaboration time.
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535 ||
        GO_HOLD < 1 || GO_HOLD > 255 || MCW < 1) begin : g_bad_param
        $error("game_turn_ctrl: parameter out of legal range");
    end

    state_t                 state_q, state_d;
    logic [1:0]             cur_player_q, cur_player_d;
    logic [NUM_PLAYERS-1:0] play_en_q, play_en_d;
    logic                   game_over_q, game_over_d;
    logic [1:0]             result_q, result_d;
    logic [1:0]             winner_q, winner_d;
    logic [MCW-1:0]         move_cnt_q, move_cnt_d;
    logic                   timeout_skip_q, timeout_skip_d;
    logic [7:0]             go_cnt_q, go_cnt_d;
    logic [1:0]             next_player;

`ifdef TURN_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]            idle_cnt_q, idle_cnt_d;
`endif

    // Player rotation wraps after the last configured player.
    always_comb begin
        next_player = (cur_player_q == LAST_PLAYER) ? 2'd0 : cur_player_q + 2'd1;
    end

    // Next-state and registered-output computation for the turn FSM.
    always_comb begin
        state_d        = state_q;
        cur_player_d   = cur_player_q;
        result_d       = result_q;
        winner_d       = winner_q;
        move_cnt_d     = move_cnt_q;
        go_cnt_d       = go_cnt_q;
        timeout_skip_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
        idle_cnt_d     = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (play) begin
                    state_d      = S_TURN;
                    cur_player_d = 2'd0;
                    move_cnt_d   = '0;
                    result_d     = RES_NONE;
                    winner_d     = 2'd0;
`ifdef TURN_TIMEOUT_EN
                    idle_cnt_d   = '0;
`endif
                end
            end
            S_TURN: begin
                if (win) begin
                    state_d  = S_GO;
                    result_d = RES_WIN;
                    winner_d = win_id;
                    go_cnt_d = '0;
                end else if (nospc) begin
                    state_d  = S_GO;
                    result_d = RES_DRAW;
                    go_cnt_d = '0;
                end else if (play && !ill) begin
                    cur_player_d = next_player;
                    if (move_cnt_q != MC_MAX) begin
                        move_cnt_d = move_cnt_q + MC_ONE;
                    end
`ifdef TURN_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end else if (play) begin
                    // Illegal move: the player keeps the turn but is not idle.
`ifdef TURN_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end else begin
`ifdef TURN_TIMEOUT_EN
                    if (idle_cnt_q == IDLE_LAST) begin
                        cur_player_d   = next_player;
                        timeout_skip_d = 1'b1;
                        idle_cnt_d     = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
`endif
                end
            end
            S_GO: begin
                if (go_cnt_q == GO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    go_cnt_d = go_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Derived from the next state so play_en moves together with cur_player.
        game_over_d = (state_d == S_GO);
        play_en_d   = (state_d == S_TURN) ? (PE_ONE << cur_player_d) : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cur_player_q   <= 2'd0;
            play_en_q      <= '0;
            game_over_q    <= 1'b0;
            result_q       <= RES_NONE;
            winner_q       <= 2'd0;
            move_cnt_q     <= '0;
            timeout_skip_q <= 1'b0;
            go_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            cur_player_q   <= cur_player_d;
            play_en_q      <= play_en_d;
            game_over_q    <= game_over_d;
            result_q       <= result_d;
            winner_q       <= winner_d;
            move_cnt_q     <= move_cnt_d;
            timeout_skip_q <= timeout_skip_d;
            go_cnt_q       <= go_cnt_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Idle-cycle counter for the turn timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign play_en      = play_en_q;
    assign cur_player   = cur_player_q;
    assign game_over    = game_over_q;
    assign result       = result_q;
    assign winner       = winner_q;
    assign move_cnt     = move_cnt_q;
    assign timeout_skip = timeout_skip_q;

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players taking turns (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, cycles a player may idle in a turn before the turn is skipped (legal 2..65535).
REQ-003 SHALL have parameter GO_HOLD, default 4, cycles spent in GO before returning to IDLE (legal 1..255).
REQ-004 SHALL have parameter MCW, default 4, width of move_cnt.
REQ-005 SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 play  in  1  start strobe in IDLE; move strobe in TURN.
REQ-009 ill  in  1  move illegal, qualifies play.
REQ-010 nospc  in  1  board full (draw).
REQ-011 win  in  1  win detected.
REQ-012 win_id  in  2  index of winning player, valid with win.
REQ-013 play_en  out  NUM_PLAYERS  one-hot move enable for the current player.
REQ-014 cur_player  out  2  index of the current player.
REQ-015 game_over  out  1  high while in GO.
REQ-016 result  out  2  00 none, 01 win, 10 draw, 11 unused.
REQ-017 winner  out  2  winning index, valid when result=01.
REQ-018 move_cnt  out  MCW  accepted moves in current game, saturating.
REQ-019 timeout_skip  out  1  one-cycle pulse when a turn is skipped.

Function
REQ-020 SHALL be a registered FSM with states IDLE, TURN, GO; all outputs registered.
REQ-021 IDLE: play=1 -> TURN next cycle; cur_player=0, move_cnt=0, result=00, winner=0, idle counter=0.
REQ-022 TURN priority per cycle: win > nospc > (play & !ill) > timeout > hold.
REQ-023 TURN, win=1 -> GO; result=01, winner=win_id.
REQ-024 TURN, nospc=1 and win=0 -> GO; result=10.
REQ-025 TURN, play=1 and ill=0 -> stay TURN; cur_player=cur_player+1, wrapping NUM_PLAYERS-1 -> 0; move_cnt+1, saturating at 2^MCW-1; idle counter=0.
REQ-026 TURN, play=1 and ill=1 -> no state, player, or count change; idle counter=0.
REQ-027 TURN, no play: idle counter+1; on reaching TIMEOUT_CYC-1, advance cur_player as REQ-025, leave move_cnt unchanged, pulse timeout_skip, and clear counter.
REQ-028 play_en SHALL be one-hot at bit cur_player in TURN, all-zero in IDLE and GO, and SHALL update in the same cycle as cur_player.
REQ-029 GO SHALL last exactly GO_HOLD cycles, then go to IDLE; play is ignored in GO.
REQ-030 result and winner SHALL hold through GO and IDLE until the next IDLE->TURN transition.
REQ-031 win_id >= NUM_PLAYERS SHALL still be latched unchanged; flagging it is the bench's job.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and set play_en=0, cur_player=0, game_over=0, result=00, winner=0, move_cnt=0, and timeout_skip=0 from any state, including mid-TURN or mid-GO.
REQ-033 rst SHALL override every input in the same cycle.

Configuration
REQ-034 Macro TURN_TIMEOUT_EN SHALL compile in the idle counter, timeout skip, and timeout_skip pulse.
REQ-035 Without TURN_TIMEOUT_EN, TURN SHALL hold indefinitely without play, and timeout_skip SHALL be tied 0; TIMEOUT_CYC is unused.

Verification
REQ-036 NUM_PLAYERS=3: play in IDLE, then 4 legal plays -> cur_player 0,1,2,0,1; play_en 001,010,100,001,010; move_cnt=4.
REQ-037 TURN with play=1 and ill=1 for 3 cycles -> cur_player and move_cnt unchanged; play_en steady.
REQ-038 win=1, win_id=1, and nospc=1 in the same cycle -> GO; result=01, winner=1; game_over high for exactly GO_HOLD=4 cycles, then IDLE.
REQ-039 TURN_TIMEOUT_EN defined, TIMEOUT_CYC=8, no play -> after 8 cycles cur_player advances, timeout_skip pulses once, move_cnt unchanged; without the macro -> no advance after 100 cycles.
REQ-040 MCW=2, 5 legal plays -> move_cnt saturates at 3.
REQ-041 rst=1 in the second GO cycle -> next cycle IDLE, all outputs zero; next play starts with cur_player=0.
